// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI3 slave with internal word-addressed SRAM
//
// Purpose: memory model behind an AXI3 master. Read and write engines are
// independent; each takes one transaction at a time, bursts of 1-16 beats.
// Ports:
//   aclk, aresetn                      clock, async active-low reset
//   ar*  (id/addr/len/size/burst)      read address channel; lock/cache/prot ignored
//   r*   (id/data/resp/last/valid)     read data channel, rready from master
//   aw*  (id/addr/len/size/burst)      write address channel; lock/cache/prot ignored
//   w*   (id/data/strb/last/valid)     write data channel, wready to master
//   b*   (id/resp/valid)               write response channel, bready from master

module axi_sram_slave #(
   parameter int MEM_AW   = 14,
   parameter int RD_DELAY = 2,
   parameter int WR_DELAY = 1
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   input  logic [3:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   input  logic [1:0]  arlock,
   input  logic [3:0]  arcache,
   input  logic [2:0]  arprot,
   input  logic        arvalid,
   output logic        arready,
   output logic [3:0]  rid,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready,
   input  logic [3:0]  awid,
   input  logic [31:0] awaddr,
   input  logic [3:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   input  logic [1:0]  awlock,
   input  logic [3:0]  awcache,
   input  logic [2:0]  awprot,
   input  logic        awvalid,
   output logic        awready,
   input  logic [3:0]  wid,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   output logic [3:0]  bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);
   localparam logic [3:0] RD_DLY      = 4'(RD_DELAY);
   localparam logic [3:0] WR_DLY_LAST = 4'(WR_DELAY - 1);

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} rd_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_DLY, W_RESP} wr_state_t;

   logic [31:0] r_mem [0:(1<<MEM_AW)-1];

   rd_state_t   r_rd_state, w_rd_next;
   logic [3:0]  r_rd_id, r_rd_len, r_rd_cnt, r_rd_dly;
   logic [31:0] r_rd_addr, r_rdata, w_rd_addr_nxt;
   logic [1:0]  r_rd_size;
   logic        r_rd_fixed, w_rd_last;

   wr_state_t   r_wr_state, w_wr_next;
   logic [3:0]  r_wr_id, r_wr_len, r_wr_cnt, r_wr_dly;
   logic [31:0] r_wr_addr;
   logic [1:0]  r_wr_size;
   logic        r_wr_fixed, r_wr_err, w_wr_beat, w_wr_cnt_end, w_wr_beat_err;

   logic        w_unused;
   assign w_unused = ^{arlock, arcache, arprot, awlock, awcache, awprot};

   // Sizes above 4 bytes cannot fit the 32-bit bus; treat them as 4 bytes.
   function automatic logic [1:0] clamp_size(input logic [2:0] s);
      return (s > 3'd2) ? 2'd2 : s[1:0];
   endfunction

   // WRAP bursts advance exactly like INCR.
   function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] s,
                                             input logic fixed);
      return fixed ? a : a + (32'd1 << s);
   endfunction

   // ---------------- read engine ----------------
   assign w_rd_last     = (r_rd_cnt == r_rd_len);
   assign w_rd_addr_nxt = next_addr(r_rd_addr, r_rd_size, r_rd_fixed);
   assign rid           = r_rd_id;
   assign rdata         = r_rdata;
   assign rresp         = 2'b00;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) r_rd_state <= R_IDLE;
      else          r_rd_state <= w_rd_next;
   end

   always_comb begin
      w_rd_next = r_rd_state;
      arready   = 1'b0;
      rvalid    = 1'b0;
      rlast     = 1'b0;
      case (r_rd_state)
         R_IDLE: begin
            arready = 1'b1;
            if (arvalid) w_rd_next = R_WAIT;
         end
         R_WAIT: begin
            if (r_rd_dly == RD_DLY) w_rd_next = R_BURST;
         end
         R_BURST: begin
            rvalid = 1'b1;
            rlast  = w_rd_last;
            if (rready && w_rd_last) w_rd_next = R_IDLE;
         end
         default: w_rd_next = R_IDLE;
      endcase
   end

   // rdata is a register loaded one beat ahead; a write landing on the same
   // word in the same cycle is not yet visible, giving read-before-write.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_rd_id    <= '0;
         r_rd_len   <= '0;
         r_rd_cnt   <= '0;
         r_rd_dly   <= '0;
         r_rd_addr  <= '0;
         r_rd_size  <= '0;
         r_rd_fixed <= 1'b0;
         r_rdata    <= '0;
      end else begin
         case (r_rd_state)
            R_IDLE: if (arvalid) begin
               r_rd_id    <= arid;
               r_rd_addr  <= araddr;
               r_rd_len   <= arlen;
               r_rd_size  <= clamp_size(arsize);
               r_rd_fixed <= (arburst == 2'b00);
               r_rd_cnt   <= '0;
               r_rd_dly   <= '0;
            end
            R_WAIT: begin
               if (r_rd_dly == RD_DLY) r_rdata <= r_mem[r_rd_addr[MEM_AW+1:2]];
               else                    r_rd_dly <= r_rd_dly + 4'd1;
            end
            R_BURST: if (rready) begin
               r_rd_cnt  <= r_rd_cnt + 4'd1;
               r_rd_addr <= w_rd_addr_nxt;
               if (!w_rd_last) r_rdata <= r_mem[w_rd_addr_nxt[MEM_AW+1:2]];
            end
            default: ;
         endcase
      end
   end

   // ---------------- write engine ----------------
   assign w_wr_beat     = (r_wr_state == W_DATA) && wvalid;
   assign w_wr_cnt_end  = (r_wr_cnt == r_wr_len);
   // wlast must coincide with the final counted beat; any disagreement is an error.
   assign w_wr_beat_err = (wid != r_wr_id) || (wlast ^ w_wr_cnt_end);
   assign bid           = r_wr_id;
   assign bresp         = {bvalid & r_wr_err, 1'b0};

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) r_wr_state <= W_IDLE;
      else          r_wr_state <= w_wr_next;
   end

   always_comb begin
      w_wr_next = r_wr_state;
      awready   = 1'b0;
      wready    = 1'b0;
      bvalid    = 1'b0;
      case (r_wr_state)
         W_IDLE: begin
            awready = 1'b1;
            if (awvalid) w_wr_next = W_DATA;
         end
         W_DATA: begin
            wready = 1'b1;
            if (wvalid && (wlast || w_wr_cnt_end))
               w_wr_next = (WR_DELAY == 0) ? W_RESP : W_DLY;
         end
         W_DLY: begin
            if (r_wr_dly == WR_DLY_LAST) w_wr_next = W_RESP;
         end
         W_RESP: begin
            bvalid = 1'b1;
            if (bready) w_wr_next = W_IDLE;
         end
         default: w_wr_next = W_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_wr_id    <= '0;
         r_wr_len   <= '0;
         r_wr_cnt   <= '0;
         r_wr_dly   <= '0;
         r_wr_addr  <= '0;
         r_wr_size  <= '0;
         r_wr_fixed <= 1'b0;
         r_wr_err   <= 1'b0;
      end else begin
         case (r_wr_state)
            W_IDLE: if (awvalid) begin
               r_wr_id    <= awid;
               r_wr_addr  <= awaddr;
               r_wr_len   <= awlen;
               r_wr_size  <= clamp_size(awsize);
               r_wr_fixed <= (awburst == 2'b00);
               r_wr_cnt   <= '0;
               r_wr_dly   <= '0;
               r_wr_err   <= 1'b0;
            end
            W_DATA: if (wvalid) begin
               r_wr_cnt  <= r_wr_cnt + 4'd1;
               r_wr_addr <= next_addr(r_wr_addr, r_wr_size, r_wr_fixed);
               if (w_wr_beat_err) r_wr_err <= 1'b1;
            end
            W_DLY: r_wr_dly <= r_wr_dly + 4'd1;
            default: ;
         endcase
      end
   end

   // Memory array has no reset; errored beats are still written.
   always_ff @(posedge aclk) begin
      if (w_wr_beat) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) r_mem[r_wr_addr[MEM_AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - self-checking bench for axi_sram_slave

module tb_axi_sram_slave;
   localparam int MEM_AW   = 14;
   localparam int RD_DELAY = 2;
   localparam int WR_DELAY = 1;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [3:0]  arid, awid, wid, rid, bid;
   logic [31:0] araddr, awaddr, wdata, rdata;
   logic [3:0]  arlen, awlen, wstrb;
   logic [2:0]  arsize, awsize;
   logic [1:0]  arburst, awburst, rresp, bresp;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

   always #5 aclk = ~aclk;

   axi_sram_slave #(.MEM_AW(MEM_AW), .RD_DELAY(RD_DELAY), .WR_DELAY(WR_DELAY)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(2'b00), .arcache(4'h0), .arprot(3'b000), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(2'b00), .awcache(4'h0), .awprot(3'b000), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] model [int];
   logic [31:0] wbuf_d [16];
   logic [3:0]  wbuf_s [16];
   logic [31:0] rd_q [16];
   logic [1:0]  wr_bresp;
   logic [3:0]  wr_bid;

   typedef struct {
      logic [31:0] init_addr;
      logic [31:0] init;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [3:0]  strb;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl [5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % (32'd1 << MEM_AW));
   endfunction

   function automatic logic [31:0] mget(input logic [31:0] a);
      if (model.exists(widx(a))) return model[widx(a)];
      return 32'hxxxxxxxx;
   endfunction

   function automatic logic [31:0] step(input logic [31:0] a, input logic [2:0] sz,
                                        input logic [1:0] bu);
      int bytes;
      bytes = 1 << ((sz > 3'd2) ? 2 : int'(sz));
      return (bu == 2'b00) ? a : a + 32'(bytes);
   endfunction

   function automatic logic pick(input int mode, input int pat);
      if (mode == 0) return 1'b1;
      if (mode == 1) return (pat % 3) == 0;
      return ($urandom % 3) != 0;
   endfunction

   task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] sz, input logic [1:0] bu, input int mode);
      logic [31:0] a, hd;
      logic        hl;
      logic [3:0]  hid;
      int          guard, cnt, pat;
      arid = id; araddr = addr; arlen = len; arsize = sz; arburst = bu; arvalid = 1'b1;
      guard = 0;
      while (!arready && guard < 100) begin @(posedge aclk); #1; guard++; end
      chk("rd_ar_accept", {31'd0, arready}, 32'd1);
      @(posedge aclk); #1;
      arvalid = 1'b0;
      cnt = 0;
      while (!rvalid && cnt < 100) begin @(posedge aclk); #1; cnt++; end
      chk("rd_latency", 32'(cnt), 32'(RD_DELAY + 1));
      a = addr; pat = 0;
      for (int b = 0; b <= int'(len); b++) begin
         rready = pick(mode, pat); pat++;
         guard = 0;
         while (!rready && guard < 20) begin
            hd = rdata; hl = rlast; hid = rid;
            @(posedge aclk); #1;
            chk("rd_hold_valid", {31'd0, rvalid}, 32'd1);
            chk("rd_hold_data", rdata, hd);
            chk("rd_hold_last", {31'd0, rlast}, {31'd0, hl});
            chk("rd_hold_id", {28'd0, rid}, {28'd0, hid});
            rready = pick(mode, pat); pat++; guard++;
         end
         rready = 1'b1;
         chk("rd_valid", {31'd0, rvalid}, 32'd1);
         chk("rd_data", rdata, mget(a));
         chk("rd_last", {31'd0, rlast}, {31'd0, b == int'(len)});
         chk("rd_id", {28'd0, rid}, {28'd0, id});
         chk("rd_resp", {30'd0, rresp}, 32'd0);
         rd_q[b] = rdata;
         @(posedge aclk); #1;
         rready = 1'b0;
         a = step(a, sz, bu);
      end
      chk("rd_done", {30'd0, rvalid, arready}, 32'd1);
   endtask

   task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] sz, input logic [1:0] bu, input int last_at,
                           input logic [3:0] wid_v, input int bdly, input bit gaps);
      logic [31:0] a, w;
      bit          err;
      int          nb, guard, cnt;
      awid = id; awaddr = addr; awlen = len; awsize = sz; awburst = bu; awvalid = 1'b1;
      guard = 0;
      while (!awready && guard < 100) begin @(posedge aclk); #1; guard++; end
      chk("wr_aw_accept", {31'd0, awready}, 32'd1);
      @(posedge aclk); #1;
      awvalid = 1'b0;
      a = addr; err = 0;
      nb = ((last_at < int'(len)) ? last_at : int'(len)) + 1;
      for (int k = 0; k < nb; k++) begin
         wid = wid_v; wdata = wbuf_d[k]; wstrb = wbuf_s[k]; wlast = (k == last_at);
         wvalid = gaps ? (($urandom % 3) != 0) : 1'b1;
         guard = 0;
         while (!(wvalid && wready) && guard < 30) begin
            @(posedge aclk); #1;
            guard++;
            wvalid = (gaps && guard < 10) ? (($urandom % 3) != 0) : 1'b1;
         end
         chk("wr_beat_accept", {31'd0, wvalid && wready}, 32'd1);
         w = mget(a);
         for (int i = 0; i < 4; i++) if (wbuf_s[k][i]) w[8*i +: 8] = wbuf_d[k][8*i +: 8];
         model[widx(a)] = w;
         if (wid_v != id || (wlast && k != int'(len)) || (!wlast && k == int'(len))) err = 1;
         @(posedge aclk); #1;
         a = step(a, sz, bu);
      end
      wvalid = 1'b0; wlast = 1'b0;
      chk("wr_wready_off", {31'd0, wready}, 32'd0);
      cnt = 0;
      while (!bvalid && cnt < 100) begin @(posedge aclk); #1; cnt++; end
      chk("wr_latency", 32'(cnt), 32'(WR_DELAY));
      for (int i = 0; i < bdly; i++) begin
         @(posedge aclk); #1;
         chk("wr_bvalid_hold", {31'd0, bvalid}, 32'd1);
      end
      chk("wr_bid", {28'd0, bid}, {28'd0, id});
      chk("wr_bresp", {30'd0, bresp}, {30'd0, err, 1'b0});
      wr_bresp = bresp; wr_bid = bid;
      bready = 1'b1;
      @(posedge aclk); #1;
      bready = 1'b0;
      chk("wr_done", {30'd0, bvalid, awready}, 32'd1);
   endtask

   task automatic wr1(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s);
      wbuf_d[0] = d; wbuf_s[0] = s;
      do_write(4'h1, addr, 4'd0, 3'd2, 2'b01, 0, 4'h1, 0, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0]  ln, id;
      logic [2:0]  sz;
      logic [1:0]  bu;
      logic [31:0] ad;

      tbl[0] = '{32'h200, 32'hAAAAAAAA, 32'h0000_0200, 32'h11223344, 4'b0101, 32'hAA22AA44};
      tbl[1] = '{32'h204, 32'hAAAAAAAA, 32'h0001_0204, 32'h11223344, 4'b1111, 32'h11223344};
      tbl[2] = '{32'h208, 32'h55555555, 32'h0000_0208, 32'h12345678, 4'b0000, 32'h55555555};
      tbl[3] = '{32'h20C, 32'hAAAAAAAA, 32'hFFFF_020C, 32'h11223344, 4'b1000, 32'h11AAAAAA};
      tbl[4] = '{32'h210, 32'h00000000, 32'h0000_0212, 32'hCAFEF00D, 4'b0010, 32'h0000F000};

      arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0; rready = 0;
      awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
      wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
      aresetn = 1'b1;
      #3 aresetn = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
      chk("rst_rlast", {31'd0, rlast}, 32'd0);
      chk("rst_wready", {31'd0, wready}, 32'd0);
      chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
      chk("rst_rid_bid", {24'd0, rid, bid}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_resp", {28'd0, rresp, bresp}, 32'd0);
      aresetn = 1'b1;
      @(posedge aclk); #1;
      chk("rst_arready", {31'd0, arready}, 32'd1);
      chk("rst_awready", {31'd0, awready}, 32'd1);

      // single read after preload
      wr1(32'h40, 32'hDEADBEEF, 4'hF);
      do_read(4'h3, 32'h40, 4'd0, 3'd2, 2'b01, 0);
      chk("single_rdata", rd_q[0], 32'hDEADBEEF);

      // 4-beat INCR read with rready 1,0,0,1...
      for (int k = 0; k < 4; k++) begin wbuf_d[k] = 32'h1000_0100 + 32'(k); wbuf_s[k] = 4'hF; end
      do_write(4'h2, 32'h100, 4'd3, 3'd2, 2'b01, 3, 4'h2, 0, 1'b0);
      do_read(4'h7, 32'h100, 4'd3, 3'd2, 2'b01, 1);
      chk("incr4_beat4", rd_q[3], 32'h1000_0103);

      // byte-strobe and aliasing table
      for (int t = 0; t < 5; t++) begin
         wr1(tbl[t].init_addr, tbl[t].init, 4'hF);
         wr1(tbl[t].addr, tbl[t].wd, tbl[t].strb);
         do_read(4'hA, tbl[t].init_addr, 4'd0, 3'd2, 2'b01, 0);
         chk("strb_table", rd_q[0], tbl[t].exp);
      end

      // early wlast on beat 2 of 4
      for (int k = 0; k < 4; k++) begin wbuf_d[k] = 32'hA000_0000 + 32'(k); wbuf_s[k] = 4'hF; end
      do_write(4'h1, 32'h300, 4'd3, 3'd2, 2'b01, 3, 4'h1, 0, 1'b0);
      for (int k = 0; k < 4; k++) wbuf_d[k] = 32'hB000_0000 + 32'(k);
      do_write(4'h6, 32'h300, 4'd3, 3'd2, 2'b01, 1, 4'h6, 3, 1'b0);
      chk("early_wlast_bresp", {30'd0, wr_bresp}, 32'd2);
      chk("early_wlast_bid", {28'd0, wr_bid}, 32'd6);
      do_read(4'h2, 32'h300, 4'd3, 3'd2, 2'b01, 0);
      chk("early_wlast_b1", rd_q[1], 32'hB000_0001);
      chk("early_wlast_b2", rd_q[2], 32'hA000_0002);

      // missing wlast and wrong wid both give SLVERR
      wbuf_d[0] = 32'h600; wbuf_d[1] = 32'h604; wbuf_s[0] = 4'hF; wbuf_s[1] = 4'hF;
      do_write(4'h1, 32'h600, 4'd1, 3'd2, 2'b01, 99, 4'h1, 0, 1'b0);
      chk("no_wlast_bresp", {30'd0, wr_bresp}, 32'd2);
      do_write(4'h2, 32'h500, 4'd0, 3'd2, 2'b01, 0, 4'h3, 1, 1'b0);
      chk("bad_wid_bresp", {30'd0, wr_bresp}, 32'd2);

      // FIXED read concurrent with an unrelated write
      wr1(32'h80, 32'h8080_1234, 4'hF);
      wbuf_d[0] = 32'h0BADCAFE; wbuf_s[0] = 4'hF;
      fork
         do_read(4'h9, 32'h80, 4'd2, 3'd2, 2'b00, 1);
         do_write(4'h4, 32'h400, 4'd0, 3'd2, 2'b01, 0, 4'h4, 1, 1'b0);
      join
      chk("fixed_b0", rd_q[0], 32'h8080_1234);
      chk("fixed_b2", rd_q[2], 32'h8080_1234);
      do_read(4'h1, 32'h400, 4'd0, 3'd2, 2'b01, 0);
      chk("concurrent_wr", rd_q[0], 32'h0BADCAFE);

      // randomized bursts against the model
      for (int blk = 0; blk < 4; blk++) begin
         for (int k = 0; k < 16; k++) begin wbuf_d[k] = $urandom; wbuf_s[k] = 4'hF; end
         do_write(4'h0, 32'h1000 + 32'(blk * 64), 4'd15, 3'd2, 2'b01, 15, 4'h0, 0, 1'b0);
      end
      for (int it = 0; it < 30; it++) begin
         ln = 4'($urandom_range(0, 15)); sz = 3'($urandom_range(0, 3));
         bu = 2'($urandom_range(0, 2)); ad = 32'h1000 + 32'($urandom_range(0, 191));
         id = 4'($urandom);
         for (int k = 0; k < 16; k++) begin wbuf_d[k] = $urandom; wbuf_s[k] = 4'($urandom); end
         do_write(id, ad, ln, sz, bu, int'(ln), id, $urandom_range(0, 2), 1'b1);
         ln = 4'($urandom_range(0, 15)); sz = 3'($urandom_range(0, 3));
         bu = 2'($urandom_range(0, 2)); ad = 32'h1000 + 32'($urandom_range(0, 191));
         do_read(4'($urandom), ad, ln, sz, bu, 2);
      end

      // reset during beat 2 of an 8-beat read
      arid = 4'h5; araddr = 32'h1000; arlen = 4'd7; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
      @(posedge aclk); #1;
      arvalid = 1'b0;
      for (int g = 0; g < 20 && !rvalid; g++) begin @(posedge aclk); #1; end
      rready = 1'b1;
      @(posedge aclk); #1;
      chk("rst_mid_beat2", rdata, mget(32'h1004));
      aresetn = 1'b0; rready = 1'b0;
      #1;
      chk("rst_mid_rvalid", {31'd0, rvalid}, 32'd0);
      chk("rst_mid_rdata", rdata, 32'd0);
      repeat (2) @(posedge aclk);
      #1 aresetn = 1'b1;
      @(posedge aclk); #1;
      chk("rst_mid_arready", {31'd0, arready}, 32'd1);
      chk("rst_mid_idle", {31'd0, rvalid}, 32'd0);
      do_read(4'hC, 32'h1010, 4'd1, 3'd2, 2'b01, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
